// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store initiator for the word-wide data memory.
// Sub-word stores are read-modify-write; define LSU_READBACK_EN to verify every store by reading it back.
module load_store_unit #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [1:0]  reqSize,
    input  logic        reqSigned,
    input  logic [31:0] reqAddress,
    input  logic [31:0] reqData,
    output logic        rspValid,
    output logic [31:0] rspData,
    output logic        rspError,
    output logic [31:0] memAddress,
    output logic        memWriteEnable,
    output logic [31:0] memDataIn,
    input  logic [31:0] memDataOut
);
    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        RESP
`ifdef LSU_READBACK_EN
        , VERIFY
`endif
    } state_t;

    localparam logic [1:0] LAT = READ_LATENCY[1:0];

    state_t      state;
    logic [1:0]  cnt;
    logic        opWrite;
    logic        opSigned;
    logic [1:0]  opSize;
    logic [1:0]  opLane;
    logic [31:0] opData;

    logic        misaligned;
    logic [4:0]  shamt;
    logic [31:0] laneWord;
    logic [31:0] loadVal;
    logic [31:0] laneMask;
    logic [31:0] mergeWord;

    // Lane extraction and merge both work off the registered request and the raw memory word.
    always_comb begin
        misaligned = (reqSize == 2'b11) ||
                     (reqSize == 2'b01 && reqAddress[0]) ||
                     (reqSize == 2'b10 && reqAddress[1:0] != 2'b00);
        shamt    = {opLane, 3'b000};
        laneWord = memDataOut >> shamt;
        loadVal  = laneWord;
        laneMask = 32'hFFFF_FFFF;
        case (opSize)
            2'b00: begin
                loadVal  = {{24{opSigned & laneWord[7]}}, laneWord[7:0]};
                laneMask = 32'h0000_00FF << shamt;
            end
            2'b01: begin
                loadVal  = {{16{opSigned & laneWord[15]}}, laneWord[15:0]};
                laneMask = 32'h0000_FFFF << shamt;
            end
            default: ;
        endcase
        mergeWord = (memDataOut & ~laneMask) | ((opData << shamt) & laneMask);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state          <= IDLE;
            cnt            <= 2'd0;
            reqReady       <= 1'b0;
            rspValid       <= 1'b0;
            rspData        <= 32'd0;
            rspError       <= 1'b0;
            memAddress     <= 32'd0;
            memWriteEnable <= 1'b0;
            memDataIn      <= 32'd0;
            opWrite        <= 1'b0;
            opSigned       <= 1'b0;
            opSize         <= 2'd0;
            opLane         <= 2'd0;
            opData         <= 32'd0;
        end else begin
            rspValid       <= 1'b0;
            memWriteEnable <= 1'b0;
            case (state)
                IDLE: begin
                    reqReady <= 1'b1;
                    if (reqValid && reqReady) begin
                        reqReady <= 1'b0;
                        opWrite  <= reqWrite;
                        opSigned <= reqSigned;
                        opSize   <= reqSize;
                        opLane   <= reqAddress[1:0];
                        opData   <= reqData;
                        cnt      <= LAT;
                        if (misaligned) begin
                            rspValid <= 1'b1;
                            rspError <= 1'b1;
                            rspData  <= 32'd0;
                            state    <= RESP;
                        end else begin
                            memAddress <= {reqAddress[31:2], 2'b00};
                            if (reqWrite && reqSize == 2'b10) begin
                                memDataIn      <= reqData;
                                memWriteEnable <= 1'b1;
                                state          <= WRITE;
                            end else begin
                                state <= READ;
                            end
                        end
                    end
                end
                READ: begin
                    if (cnt == 2'd0) begin
                        if (opWrite) begin
                            memDataIn      <= mergeWord;
                            memWriteEnable <= 1'b1;
                            state          <= WRITE;
                        end else begin
                            rspData  <= loadVal;
                            rspError <= 1'b0;
                            rspValid <= 1'b1;
                            state    <= RESP;
                        end
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                WRITE: begin
`ifdef LSU_READBACK_EN
                    cnt   <= LAT;
                    state <= VERIFY;
`else
                    rspData  <= 32'd0;
                    rspError <= 1'b0;
                    rspValid <= 1'b1;
                    state    <= RESP;
`endif
                end
`ifdef LSU_READBACK_EN
                VERIFY: begin
                    if (cnt == 2'd0) begin
                        rspData  <= memDataOut;
                        rspError <= (memDataOut != memDataIn);
                        rspValid <= 1'b1;
                        state    <= RESP;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
`endif
                RESP: begin
                    // Memory bus returns to zero whenever the unit is idle.
                    rspData    <= 32'd0;
                    rspError   <= 1'b0;
                    memAddress <= 32'd0;
                    memDataIn  <= 32'd0;
                    reqReady   <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: one instance per READ_LATENCY 0..3, each with its own memory model,
// vector table, held-request and mid-operation reset sequences.
module tb_load_store_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          w;
        logic [1:0]  sz;
        bit          sg;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] expData;
        bit          expErr;
        int          expWe;
    } vec_t;

    int totalRun = 0;
    int totalFail = 0;

    for (genvar g = 0; g < 4; g++) begin : lane
        localparam int RL = g;

        logic        resetN, reqValid, reqReady, reqWrite, reqSigned;
        logic        rspValid, rspError, memWriteEnable;
        logic [1:0]  reqSize;
        logic [31:0] reqAddress, reqData, rspData, memAddress, memDataIn, memDataOut;
        logic        memClr;
        logic [31:0] mem [0:255];
        logic [31:0] rdPipe [0:3];
        int cyc = 0, weCount = 0, acceptCount = 0, idleViol = 0;
        int nRun = 0, nFail = 0;
        bit done = 1'b0;

        load_store_unit #(.READ_LATENCY(RL)) u (
            .clk(clk), .resetN(resetN), .reqValid(reqValid), .reqReady(reqReady),
            .reqWrite(reqWrite), .reqSize(reqSize), .reqSigned(reqSigned),
            .reqAddress(reqAddress), .reqData(reqData), .rspValid(rspValid),
            .rspData(rspData), .rspError(rspError), .memAddress(memAddress),
            .memWriteEnable(memWriteEnable), .memDataIn(memDataIn), .memDataOut(memDataOut)
        );

        always @(posedge clk) begin
            if (memClr) begin
                for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
            end else if (memWriteEnable) begin
                mem[memAddress[9:2]] <= memDataIn;
            end
            rdPipe[0] <= mem[memAddress[9:2]];
            for (int i = 1; i < 4; i++) rdPipe[i] <= rdPipe[i-1];
        end

        if (RL == 0) begin : comb
            assign memDataOut = mem[memAddress[9:2]];
        end else begin : piped
            assign memDataOut = rdPipe[RL-1];
        end

        always @(posedge clk) cyc <= cyc + 1;
        always @(negedge clk) begin
            if (memWriteEnable) weCount <= weCount + 1;
            if (reqValid && reqReady) acceptCount <= acceptCount + 1;
            if (resetN && reqReady && (memWriteEnable || memAddress != 0 || memDataIn != 0))
                idleViol <= idleViol + 1;
        end

        function automatic int expLat(input bit w, input logic [1:0] sz, input bit err);
            if (err) return 1;
            if (w && sz == 2'b10) return 2;
            if (!w) return 2 + RL;
            return 3 + RL;
        endfunction

        task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
            nRun++;
            if (act !== exp) begin
                nFail++;
                $display("FAIL lat%0d %s: got %h expected %h", RL, name, act, exp);
            end
        endtask

        // Issue one request from a negedge; hold keeps reqValid high and scrambles fields after acceptance.
        task automatic doReq(input bit w, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                             input logic [31:0] d, input bit hold,
                             output logic [31:0] rd, output logic er, output int lat);
            int t0, k;
            reqValid = 1'b1; reqWrite = w; reqSize = sz; reqSigned = sg; reqAddress = a; reqData = d;
            k = 0;
            while (!reqReady && k < 20) begin @(negedge clk); k++; end
            t0 = cyc;
            @(negedge clk);
            if (hold) begin
                reqData = ~d;
                reqAddress = a ^ 32'h4;
                reqSigned = ~sg;
            end else begin
                reqValid = 1'b0;
            end
            lat = -1; rd = 32'hDEAD_BEEF; er = 1'b1;
            for (int i = 0; i < 20 && lat < 0; i++) begin
                if (rspValid) begin
                    lat = cyc - t0; rd = rspData; er = rspError;
                end else begin
                    @(negedge clk);
                end
            end
            reqValid = 1'b0;
            @(negedge clk);
        endtask

        initial begin
            logic [31:0] rd;
            logic er;
            int lat, we0, acc0;
            vec_t vt [21];
            vt[0]  = '{1'b1, 2'b10, 1'b0, 32'h0000, 32'd1234,      32'h0,         1'b0, 1};
            vt[1]  = '{1'b0, 2'b10, 1'b0, 32'h0000, 32'h0,         32'd1234,      1'b0, 0};
            vt[2]  = '{1'b1, 2'b10, 1'b0, 32'h0010, 32'h11223344,  32'h0,         1'b0, 1};
            vt[3]  = '{1'b1, 2'b00, 1'b0, 32'h0012, 32'h000000AB,  32'h0,         1'b0, 1};
            vt[4]  = '{1'b0, 2'b10, 1'b0, 32'h0010, 32'h0,         32'h11AB3344,  1'b0, 0};
            vt[5]  = '{1'b1, 2'b00, 1'b0, 32'h0021, 32'h00000080,  32'h0,         1'b0, 1};
            vt[6]  = '{1'b0, 2'b00, 1'b1, 32'h0021, 32'h0,         32'hFFFFFF80,  1'b0, 0};
            vt[7]  = '{1'b0, 2'b00, 1'b0, 32'h0021, 32'h0,         32'h00000080,  1'b0, 0};
            vt[8]  = '{1'b1, 2'b01, 1'b0, 32'h0022, 32'h00008001,  32'h0,         1'b0, 1};
            vt[9]  = '{1'b0, 2'b01, 1'b1, 32'h0022, 32'h0,         32'hFFFF8001,  1'b0, 0};
            vt[10] = '{1'b0, 2'b10, 1'b0, 32'h0020, 32'h0,         32'h80018000,  1'b0, 0};
            vt[11] = '{1'b0, 2'b10, 1'b0, 32'h1235, 32'h0,         32'h0,         1'b1, 0};
            vt[12] = '{1'b1, 2'b01, 1'b0, 32'h0033, 32'h00005555,  32'h0,         1'b1, 0};
            vt[13] = '{1'b0, 2'b11, 1'b0, 32'h0030, 32'h0,         32'h0,         1'b1, 0};
            vt[14] = '{1'b0, 2'b10, 1'b0, 32'h0030, 32'h0,         32'h0,         1'b0, 0};
            vt[15] = '{1'b0, 2'b01, 1'b0, 32'h0012, 32'h0,         32'h000011AB,  1'b0, 0};
            vt[16] = '{1'b0, 2'b00, 1'b1, 32'h0013, 32'h0,         32'h00000011,  1'b0, 0};
            vt[17] = '{1'b1, 2'b00, 1'b0, 32'h0013, 32'hFFFFFFFF,  32'h0,         1'b0, 1};
            vt[18] = '{1'b0, 2'b10, 1'b0, 32'h0010, 32'h0,         32'hFFAB3344,  1'b0, 0};
            vt[19] = '{1'b0, 2'b01, 1'b1, 32'h0010, 32'h0,         32'h00003344,  1'b0, 0};
            vt[20] = '{1'b0, 2'b01, 1'b1, 32'h0012, 32'h0,         32'hFFFFFFAB,  1'b0, 0};

            resetN = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'b00; reqSigned = 1'b0;
            reqAddress = 32'd0; reqData = 32'd0; memClr = 1'b1;
            #2 resetN = 1'b0;
            repeat (2) @(negedge clk);
            check("rst reqReady", {31'd0, reqReady}, 32'd0);
            check("rst rspValid", {31'd0, rspValid}, 32'd0);
            check("rst rspError", {31'd0, rspError}, 32'd0);
            check("rst memWriteEnable", {31'd0, memWriteEnable}, 32'd0);
            check("rst rspData", rspData, 32'd0);
            check("rst memAddress", memAddress, 32'd0);
            check("rst memDataIn", memDataIn, 32'd0);
            resetN = 1'b1; memClr = 1'b0;
            @(negedge clk);
            check("ready after rst", {31'd0, reqReady}, 32'd1);

            foreach (vt[i]) begin
                we0 = weCount;
                doReq(vt[i].w, vt[i].sz, vt[i].sg, vt[i].addr, vt[i].data, 1'b0, rd, er, lat);
                check($sformatf("v%0d data", i), rd, vt[i].expData);
                check($sformatf("v%0d err", i), {31'd0, er}, {31'd0, vt[i].expErr});
                check($sformatf("v%0d latency", i), lat, expLat(vt[i].w, vt[i].sz, vt[i].expErr));
                check($sformatf("v%0d writes", i), weCount - we0, vt[i].expWe);
            end

            // Held request with fields changing while busy.
            acc0 = acceptCount; we0 = weCount;
            doReq(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, 1'b1, rd, er, lat);
            check("hold word latency", lat, expLat(1'b1, 2'b10, 1'b0));
            check("hold word accepts", acceptCount - acc0, 1);
            check("hold word writes", weCount - we0, 1);
            acc0 = acceptCount; we0 = weCount;
            doReq(1'b1, 2'b00, 1'b0, 32'h41, 32'h0000005A, 1'b1, rd, er, lat);
            check("hold byte latency", lat, expLat(1'b1, 2'b00, 1'b0));
            check("hold byte accepts", acceptCount - acc0, 1);
            check("hold byte writes", weCount - we0, 1);
            doReq(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0, rd, er, lat);
            check("hold readback", rd, 32'hCAFE5A0D);
            doReq(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 1'b0, rd, er, lat);
            check("hold neighbour untouched", rd, 32'h0);

            // Reset during the read phase of a sub-word store.
            doReq(1'b1, 2'b10, 1'b0, 32'h44, 32'h99999999, 1'b0, rd, er, lat);
            we0 = weCount;
            reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'b00; reqSigned = 1'b0;
            reqAddress = 32'h44; reqData = 32'h77;
            @(negedge clk);
            reqValid = 1'b0;
            check("busy before rst", {31'd0, reqReady}, 32'd0);
            resetN = 1'b0;
            #1;
            check("midrst reqReady", {31'd0, reqReady}, 32'd0);
            check("midrst memAddress", memAddress, 32'd0);
            check("midrst memWriteEnable", {31'd0, memWriteEnable}, 32'd0);
            check("midrst rspValid", {31'd0, rspValid}, 32'd0);
            repeat (4) @(negedge clk);
            check("midrst writes", weCount - we0, 0);
            resetN = 1'b1;
            @(negedge clk);
            doReq(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 1'b0, rd, er, lat);
            check("after rst no write", rd, 32'h99999999);
            doReq(1'b1, 2'b00, 1'b0, 32'h45, 32'h77, 1'b0, rd, er, lat);
            check("after rst store err", {31'd0, er}, 32'd0);
            doReq(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 1'b0, rd, er, lat);
            check("after rst store data", rd, 32'h99997799);

            check("idle bus quiet", idleViol, 0);
            done = 1'b1;
        end
    end

    initial begin
        int k;
        k = 0;
        while (!(lane[0].done && lane[1].done && lane[2].done && lane[3].done) && k < 20000) begin
            @(posedge clk);
            k++;
        end
        totalRun = lane[0].nRun + lane[1].nRun + lane[2].nRun + lane[3].nRun;
        totalFail = lane[0].nFail + lane[1].nFail + lane[2].nFail + lane[3].nFail;
        if (k >= 20000) begin
            totalRun++;
            totalFail++;
            $display("FAIL timeout: lanes done %b required 1111",
                     {lane[3].done, lane[2].done, lane[1].done, lane[0].done});
        end
        $display("[TB] %0d tests run, %0d failed", totalRun, totalFail);
        $finish;
    end
endmodule
